// File: rtl/crc16_frame_arb.sv
// Two-port frame arbiter that appends a CRC-16 to every forwarded frame.
//
// A requester is granted at frame granularity (round-robin on ties). Its payload
// bytes are passed straight through to the output and fed to a shared external
// CRC-16 engine. After the last payload byte the block waits ENGINE_LAT cycles
// for the engine, captures its result and emits it as two trailing bytes, MSB first.
//
// Ports:
//   clk_i                      single clock, rising edge
//   rst_i                      synchronous, active-high reset
//   s0_data_i  / s1_data_i     requester payload byte
//   s0_valid_i / s1_valid_i    requester byte valid
//   s0_last_i  / s1_last_i     byte is the final payload byte of its frame
//   s0_ready_o / s1_ready_o    requester byte accepted when ready && valid
//   m_data_o                   output byte (payload or appended CRC)
//   m_valid_o / m_last_o       output byte valid / final byte of output frame
//   m_src_o                    index of the granted requester
//   m_ready_i                  downstream accepts the byte
//   crc_clr_o                  one-cycle clear of the CRC engine
//   crc_data_o / crc_valid_o   byte fed to the engine / byte strobe
//   crc_in_i                   engine CRC result
module crc16_frame_arb #(
    parameter int unsigned ENGINE_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  s0_data_i,
    input  logic        s0_valid_i,
    input  logic        s0_last_i,
    output logic        s0_ready_o,
    input  logic [7:0]  s1_data_i,
    input  logic        s1_valid_i,
    input  logic        s1_last_i,
    output logic        s1_ready_o,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    output logic        m_src_o,
    input  logic        m_ready_i,
    output logic        crc_clr_o,
    output logic [7:0]  crc_data_o,
    output logic        crc_valid_o,
    input  logic [15:0] crc_in_i
);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StPass,
        StWait,
        StCrcHi,
        StCrcLo
    } state_e;

    localparam logic [2:0] CntLoad = 3'(ENGINE_LAT - 1);

    state_e      state_q, state_d;
    logic        src_q, src_d;
    logic        last_srv_q, last_srv_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;

    // Granted-port view of the requester inputs.
    logic [7:0] g_data;
    logic       g_valid;
    logic       g_last;

    always_comb begin
        g_data  = src_q ? s1_data_i  : s0_data_i;
        g_valid = src_q ? s1_valid_i : s0_valid_i;
        g_last  = src_q ? s1_last_i  : s0_last_i;
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        last_srv_d = last_srv_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;

        s0_ready_o  = 1'b0;
        s1_ready_o  = 1'b0;
        m_data_o    = 8'h00;
        m_valid_o   = 1'b0;
        m_last_o    = 1'b0;
        m_src_o     = src_q;
        crc_clr_o   = 1'b0;
        crc_data_o  = 8'h00;
        crc_valid_o = 1'b0;

        // Outputs stay quiet during reset even if the state register is mid-frame.
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (s0_valid_i || s1_valid_i) begin
                        // Tie goes to the port not served last; a sole requester wins.
                        src_d   = (s0_valid_i && s1_valid_i) ? ~last_srv_q : s1_valid_i;
                        state_d = StGrant;
                    end
                end
                StGrant: begin
                    crc_clr_o = 1'b1;
                    state_d   = StPass;
                end
                StPass: begin
                    m_data_o   = g_data;
                    m_valid_o  = g_valid;
                    s0_ready_o = ~src_q & m_ready_i;
                    s1_ready_o = src_q & m_ready_i;
                    if (g_valid && m_ready_i) begin
                        crc_valid_o = 1'b1;
                        crc_data_o  = g_data;
                        if (g_last) begin
                            state_d = StWait;
                            cnt_d   = CntLoad;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        hold_d  = crc_in_i;
                        state_d = StCrcHi;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StCrcHi: begin
                    m_valid_o = 1'b1;
                    m_data_o  = hold_q[15:8];
                    if (m_ready_i) begin
                        state_d = StCrcLo;
                    end
                end
                StCrcLo: begin
                    m_valid_o = 1'b1;
                    m_data_o  = hold_q[7:0];
                    m_last_o  = 1'b1;
                    if (m_ready_i) begin
                        last_srv_d = src_q;
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            src_q      <= 1'b0;
            last_srv_q <= 1'b1;
            cnt_q      <= 3'd0;
            hold_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_srv_q <= last_srv_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
        end
    end

endmodule
